// File: rtl/branch_redirect_unit_pkg.sv
// Shared types, sizes and the wrap-aware ROB age compare for the branch redirect path.
package branch_redirect_unit_pkg;

   localparam int unsigned ALU_NUM      = 4;
   localparam int unsigned ROB_IDX_W    = 6;
   localparam int unsigned FSQ_IDX_W    = 5;
   localparam int unsigned VADDR_W      = 32;
   localparam int unsigned BLOCK_CYCLES = 64;

   typedef struct packed {
      logic                 dir;
      logic [ROB_IDX_W-1:0] idx;
   } rob_idx_t;

   typedef struct packed {
      logic [VADDR_W-1:0]   target;
      logic                 taken;
      rob_idx_t             robidx;
      logic [FSQ_IDX_W-1:0] fsqidx;
   } branch_redirect_t;

   // Differing dir bits mean one index has wrapped, which inverts the compare.
   function automatic logic rob_older(rob_idx_t a, rob_idx_t b);
      return (a.dir == b.dir) ? (a.idx < b.idx) : (a.idx > b.idx);
   endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Branch-result inputs, backend flush and the redirect handshake towards the frontend.
interface branch_redirect_unit_if;
   import branch_redirect_unit_pkg::*;

   logic [ALU_NUM-1:0]               br_en;
   logic [ALU_NUM-1:0]               br_error;
   logic [ALU_NUM-1:0]               br_direction;
   logic [ALU_NUM*VADDR_W-1:0]       br_target;
   logic [ALU_NUM*(ROB_IDX_W+1)-1:0] br_robidx;
   logic [ALU_NUM*FSQ_IDX_W-1:0]     br_fsqidx;
   logic                             flush_en;
   logic [ROB_IDX_W:0]               flush_robidx;
   logic                             redirect_valid;
   logic                             redirect_ready;
   logic [VADDR_W-1:0]               redirect_target;
   logic                             redirect_taken;
   logic [ROB_IDX_W:0]               redirect_robidx;
   logic [FSQ_IDX_W-1:0]             redirect_fsqidx;

   modport master (
      output br_en, br_error, br_direction, br_target, br_robidx, br_fsqidx,
      output flush_en, flush_robidx, redirect_ready,
      input  redirect_valid, redirect_target, redirect_taken, redirect_robidx, redirect_fsqidx
   );

   modport slave (
      input  br_en, br_error, br_direction, br_target, br_robidx, br_fsqidx,
      input  flush_en, flush_robidx, redirect_ready,
      output redirect_valid, redirect_target, redirect_taken, redirect_robidx, redirect_fsqidx
   );

endinterface

// File: rtl/branch_redirect_unit_age_select.sv
// Combinational oldest-of-N select over a binary tree of rob_older compares.
// Returns the valid flag, the winning input index and its payload.
module branch_redirect_unit_age_select
   import branch_redirect_unit_pkg::*;
#(
   parameter int unsigned N = ALU_NUM,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  branch_redirect_t payload [N],
   output logic             valid,
   output logic [IDX_W-1:0] winner,
   output branch_redirect_t sel
);

   localparam int unsigned NODES = 2 * N - 1;

   logic             nv [NODES];
   logic [IDX_W-1:0] ni [NODES];
   branch_redirect_t np [NODES];

   // Heap layout: leaves at N-1.., node k has children 2k+1 (left) and 2k+2 (right).
   for (genvar i = 0; i < N; i++) begin : g_leaf
      assign nv[N-1+i] = req[i];
      assign ni[N-1+i] = IDX_W'(i);
      assign np[N-1+i] = payload[i];
   end

   for (genvar k = 0; k < N - 1; k++) begin : g_node
      logic take_right;
      // Left subtree carries the lower indices, so an age tie stays left.
      assign take_right = nv[2*k+2] &&
                          (!nv[2*k+1] || rob_older(np[2*k+2].robidx, np[2*k+1].robidx));
      assign nv[k] = nv[2*k+1] | nv[2*k+2];
      assign ni[k] = take_right ? ni[2*k+2] : ni[2*k+1];
      assign np[k] = take_right ? np[2*k+2] : np[2*k+1];
   end

   assign valid  = nv[0];
   assign winner = ni[0];
   assign sel    = np[0];

endmodule

// File: rtl/branch_redirect_unit.sv
// Picks the oldest mispredicted branch across ALUs and holds it as one pending frontend redirect.
// Optional BRU_PERF_COUNTER_EN adds saturating fire/replacement counters.
module branch_redirect_unit
   import branch_redirect_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   branch_redirect_unit_if.slave bus
`ifdef BRU_PERF_COUNTER_EN
   ,
   output logic [31:0]          perf_mispred,
   output logic [31:0]          perf_replace
`endif
);

   localparam int unsigned ALU_IDX_W = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1;
   localparam int unsigned CNT_W     = $clog2(BLOCK_CYCLES);

   branch_redirect_t     cand_pl [ALU_NUM];
   logic [ALU_NUM-1:0]   cand_req;
   logic                 sel_valid;
   logic [ALU_IDX_W-1:0] sel_alu;
   branch_redirect_t     sel_pl;

   branch_redirect_t pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;
   rob_idx_t         last_q, last_d;
   logic             block_q, block_d;
   logic [CNT_W-1:0] block_cnt_q, block_cnt_d;
   logic             fire, flush_kill, load, gate_on;
   rob_idx_t         gate_ref, flush_rob;

   assign fire      = pend_valid_q & bus.redirect_ready;
   assign flush_rob = rob_idx_t'(bus.flush_robidx);
   // The branch leaving this cycle already gates same-cycle candidates.
   assign gate_on   = fire | block_q;
   assign gate_ref  = fire ? pend_q.robidx : last_q;

   always_comb begin
      for (int i = 0; i < ALU_NUM; i++) begin
         cand_pl[i].target = bus.br_target[i*VADDR_W +: VADDR_W];
         cand_pl[i].taken  = bus.br_direction[i];
         cand_pl[i].robidx = bus.br_robidx[i*(ROB_IDX_W+1) +: (ROB_IDX_W+1)];
         cand_pl[i].fsqidx = bus.br_fsqidx[i*FSQ_IDX_W +: FSQ_IDX_W];
         cand_req[i]       = bus.br_en[i] & bus.br_error[i];
         if (bus.flush_en && !rob_older(cand_pl[i].robidx, flush_rob)) cand_req[i] = 1'b0;
         if (gate_on && !rob_older(cand_pl[i].robidx, gate_ref)) cand_req[i] = 1'b0;
      end
   end

   branch_redirect_unit_age_select #(
      .N (ALU_NUM)
   ) u_age_select (
      .req     (cand_req),
      .payload (cand_pl),
      .valid   (sel_valid),
      .winner  (sel_alu),
      .sel     (sel_pl)
   );

   always_comb begin
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      load         = 1'b0;
      flush_kill   = bus.flush_en & pend_valid_q & !rob_older(pend_q.robidx, flush_rob);
      if (flush_kill || fire) pend_valid_d = 1'b0;
      if (sel_valid && (!pend_valid_d || rob_older(sel_pl.robidx, pend_q.robidx))) load = 1'b1;
      if (load) begin
         pend_d       = sel_pl;
         pend_valid_d = 1'b1;
      end

      block_d     = block_q;
      last_d      = last_q;
      block_cnt_d = block_q ? block_cnt_q + 1'b1 : '0;
      if (block_q && block_cnt_q == CNT_W'(BLOCK_CYCLES - 1)) block_d = 1'b0;
      if (fire) begin
         block_d     = 1'b1;
         last_d      = pend_q.robidx;
         block_cnt_d = '0;
      end
      if (bus.flush_en && !rob_older(last_d, flush_rob)) block_d = 1'b0;
      if (load) block_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         last_q       <= '0;
         block_q      <= 1'b0;
         block_cnt_q  <= '0;
      end else begin
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         last_q       <= last_d;
         block_q      <= block_d;
         block_cnt_q  <= block_cnt_d;
      end
   end

   assign bus.redirect_valid  = pend_valid_q;
   assign bus.redirect_target = pend_q.target;
   assign bus.redirect_taken  = pend_q.taken;
   assign bus.redirect_robidx = pend_q.robidx;
   assign bus.redirect_fsqidx = pend_q.fsqidx;

   sel_payload_matches_winner: assert property (@(posedge clk) disable iff (!rst)
      sel_valid |-> (cand_pl[sel_alu] == sel_pl));

`ifdef BRU_PERF_COUNTER_EN
   logic        replace;
   logic [31:0] mispred_q, replace_q;

   assign replace = load & pend_valid_q & ~fire & ~flush_kill;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mispred_q <= '0;
         replace_q <= '0;
      end else begin
         if (fire && mispred_q != '1) mispred_q <= mispred_q + 32'd1;
         if (replace && replace_q != '1) replace_q <= replace_q + 32'd1;
      end
   end

   assign perf_mispred = mispred_q;
   assign perf_replace = replace_q;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit with hand-computed expected redirects.
module tb_branch_redirect_unit;
   import branch_redirect_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   branch_redirect_unit_if bus ();

`ifdef BRU_PERF_COUNTER_EN
   logic [31:0] perf_mispred, perf_replace;
`endif

   branch_redirect_unit dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef BRU_PERF_COUNTER_EN
      ,
      .perf_mispred (perf_mispred),
      .perf_replace (perf_replace)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.br_en        = '0;
      bus.br_error     = '0;
      bus.br_direction = '0;
      bus.br_target    = '0;
      bus.br_robidx    = '0;
      bus.br_fsqidx    = '0;
      bus.flush_en     = 1'b0;
      bus.flush_robidx = '0;
   endtask

   task automatic drive(input int alu, input logic [6:0] rob, input logic [31:0] tgt,
                        input logic [4:0] fsq, input logic tk);
      bus.br_en[alu]                     = 1'b1;
      bus.br_error[alu]                  = 1'b1;
      bus.br_direction[alu]              = tk;
      bus.br_target[alu*VADDR_W +: 32]   = tgt;
      bus.br_robidx[alu*(ROB_IDX_W+1) +: 7] = rob;
      bus.br_fsqidx[alu*FSQ_IDX_W +: 5]  = fsq;
   endtask

   task automatic flush(input logic [6:0] rob);
      bus.flush_en     = 1'b1;
      bus.flush_robidx = rob;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic exp_redir(input string tag, input logic [6:0] rob, input logic [31:0] tgt,
                            input logic [4:0] fsq, input logic tk);
      check({tag, "_valid"},  64'(bus.redirect_valid),  64'd1);
      check({tag, "_robidx"}, 64'(bus.redirect_robidx), 64'(rob));
      check({tag, "_target"}, 64'(bus.redirect_target), 64'(tgt));
      check({tag, "_fsqidx"}, 64'(bus.redirect_fsqidx), 64'(fsq));
      check({tag, "_taken"},  64'(bus.redirect_taken),  64'(tk));
   endtask

   initial begin
      rst = 1'b1;
      bus.redirect_ready = 1'b0;
      clear_inputs();
      #1 rst = 1'b0;
      step();
      check("rst_valid",  64'(bus.redirect_valid),  64'd0);
      check("rst_target", 64'(bus.redirect_target), 64'd0);
      check("rst_robidx", 64'(bus.redirect_robidx), 64'd0);
      check("rst_fsqidx", 64'(bus.redirect_fsqidx), 64'd0);
      check("rst_taken",  64'(bus.redirect_taken),  64'd0);
      step();
      rst = 1'b1;

      // Single mispredict, latency one, fires immediately.
      bus.redirect_ready = 1'b1;
      drive(2, 7'd5, 32'h8000_0040, 5'd17, 1'b1);
      step(); clear_inputs();
      exp_redir("single", 7'd5, 32'h8000_0040, 5'd17, 1'b1);
      step();
      check("single_drop", 64'(bus.redirect_valid), 64'd0);

      // Oldest of three; {0,9} and {1,2} are younger than {0,4}.
      drive(0, 7'd9,           32'h1000_0000, 5'd1, 1'b0);
      drive(3, 7'd4,           32'h1000_0300, 5'd3, 1'b1);
      drive(1, {1'b1, 6'd2},   32'h1000_0100, 5'd2, 1'b0);
      step(); clear_inputs();
      exp_redir("simul", 7'd4, 32'h1000_0300, 5'd3, 1'b1);
      step();
      flush(7'd4);
      step(); clear_inputs();
      // Wrap: {0,60} is older than {1,2}.
      drive(1, {1'b1, 6'd2},   32'h2000_0100, 5'd8, 1'b0);
      drive(2, 7'd60,          32'h2000_0200, 5'd9, 1'b1);
      step(); clear_inputs();
      exp_redir("wrap", 7'd60, 32'h2000_0200, 5'd9, 1'b1);
      step();
      flush(7'd60);
      step(); clear_inputs();

      // Backpressure: older replaces, younger ignored, then one fire.
      bus.redirect_ready = 1'b0;
      drive(0, 7'd10, 32'h3000_0000, 5'd4, 1'b0);
      step(); clear_inputs();
      exp_redir("bp_load", 7'd10, 32'h3000_0000, 5'd4, 1'b0);
      drive(1, 7'd7, 32'h3000_0100, 5'd5, 1'b1);
      step(); clear_inputs();
      exp_redir("bp_replace", 7'd7, 32'h3000_0100, 5'd5, 1'b1);
      drive(2, 7'd12, 32'h3000_0200, 5'd6, 1'b0);
      step(); clear_inputs();
      exp_redir("bp_ignore", 7'd7, 32'h3000_0100, 5'd5, 1'b1);
      bus.redirect_ready = 1'b1;
      step();
      check("bp_fire_drop", 64'(bus.redirect_valid), 64'd0);
      bus.redirect_ready = 1'b0;
      flush(7'd7);
      step(); clear_inputs();

      // Flush kills pending {0,10}; same-cycle older {0,3} survives.
      drive(0, 7'd10, 32'h4000_0000, 5'd7, 1'b0);
      step(); clear_inputs();
      check("fl_pre_valid", 64'(bus.redirect_valid), 64'd1);
      flush(7'd8);
      drive(1, 7'd3, 32'h4000_0100, 5'd8, 1'b1);
      step(); clear_inputs();
      exp_redir("fl_survivor", 7'd3, 32'h4000_0100, 5'd8, 1'b1);
      // Flush {0,2} kills {0,3} and discards the younger same-cycle {0,4}.
      flush(7'd2);
      drive(2, 7'd4, 32'h4000_0200, 5'd9, 1'b0);
      step(); clear_inputs();
      check("fl_drop", 64'(bus.redirect_valid), 64'd0);

      // Correct predictions never redirect.
      bus.redirect_ready = 1'b1;
      bus.br_en    = '1;
      bus.br_error = '0;
      for (int c = 0; c < 20; c++) begin
         step();
         check("noerr_valid", 64'(bus.redirect_valid), 64'd0);
      end
      clear_inputs();

      // Post-fire block: younger ignored, older passes, timeout lifts it.
      drive(0, 7'd20, 32'h5000_0000, 5'd10, 1'b1);
      step(); clear_inputs();
      exp_redir("to_load", 7'd20, 32'h5000_0000, 5'd10, 1'b1);
      step();
      check("to_drop", 64'(bus.redirect_valid), 64'd0);
      drive(1, 7'd30, 32'h5000_0100, 5'd11, 1'b0);
      step(); clear_inputs();
      check("to_blocked", 64'(bus.redirect_valid), 64'd0);
      drive(2, 7'd15, 32'h5000_0200, 5'd12, 1'b1);
      step(); clear_inputs();
      exp_redir("to_older_pass", 7'd15, 32'h5000_0200, 5'd12, 1'b1);
      for (int c = 0; c < 70; c++) step();
      drive(1, 7'd30, 32'h5000_0100, 5'd11, 1'b0);
      step(); clear_inputs();
      exp_redir("to_unblock", 7'd30, 32'h5000_0100, 5'd11, 1'b0);
      step();
      flush(7'd30);
      step(); clear_inputs();

`ifdef BRU_PERF_COUNTER_EN
      check("perf_mispred", 64'(perf_mispred), 64'd7);
      check("perf_replace", 64'(perf_replace), 64'd1);
`endif

      // Async reset while a redirect is stalled.
      bus.redirect_ready = 1'b0;
      drive(3, 7'd5, 32'h6000_0000, 5'd13, 1'b1);
      step(); clear_inputs();
      check("mid_pre_valid", 64'(bus.redirect_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_valid",  64'(bus.redirect_valid),  64'd0);
      check("mid_target", 64'(bus.redirect_target), 64'd0);
      check("mid_robidx", 64'(bus.redirect_robidx), 64'd0);
      check("mid_fsqidx", 64'(bus.redirect_fsqidx), 64'd0);
      check("mid_taken",  64'(bus.redirect_taken),  64'd0);
`ifdef BRU_PERF_COUNTER_EN
      check("mid_perf_mispred", 64'(perf_mispred), 64'd0);
`endif
      step();
      rst = 1'b1;
      bus.redirect_ready = 1'b1;
      step();
      check("post_rst_valid", 64'(bus.redirect_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Sits after the ALU cluster. Collects branch resolution results from every ALU and picks the oldest mispredicted branch.
- Holds that branch as a single pending redirect and hands it to the frontend (FSQ/BPU) over a valid/ready handshake.
- Drops candidates squashed by backend flushes. Consumer-side counterpart of the ALU's branch result output.

Parameters:
- ALU_NUM, 4, number of ALU branch-result inputs
- ROB_IDX_W, 6, ROB index bits; each robIdx carries an extra wrap (dir) bit, so total ROB_IDX_W+1
- FSQ_IDX_W, 5, fetch-stream-queue index width
- VADDR_W, 32, virtual address width (`VADDR_SIZE)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- br_en  in  ALU_NUM  per-ALU branch result valid (ALU wbData.en & branch op)
- br_error  in  ALU_NUM  per-ALU mispredict flag
- br_direction  in  ALU_NUM  resolved taken
- br_target  in  ALU_NUM*VADDR_W  resolved next PC
- br_robidx  in  ALU_NUM*(ROB_IDX_W+1)  {dir,idx} of branch
- br_fsqidx  in  ALU_NUM*FSQ_IDX_W  fetch stream of branch
- flush_en  in  1  backend squash
- flush_robidx  in  ROB_IDX_W+1  squash this entry and everything younger
- redirect_valid  out  1  pending redirect present
- redirect_ready  in  1  frontend accepts redirect
- redirect_target  out  VADDR_W  new fetch PC
- redirect_taken  out  1  resolved direction
- redirect_robidx  out  ROB_IDX_W+1  robIdx of redirecting branch
- redirect_fsqidx  out  FSQ_IDX_W  FSQ entry to repair

Behaviour:
- Age rule: older(a,b) = (a.dir==b.dir) ? a.idx<b.idx : a.idx>b.idx. Equal robIdx counts as not older.
- Candidate: input i with br_en[i] & br_error[i].
- Cycle N select: find the oldest candidate across ALUs. On an age tie the lowest ALU index wins (ties cannot occur legally).
- Pending register (valid, target, taken, robidx, fsqidx) is updated at edge N+1. redirect_valid is high in cycle N+1, so latency is 1.
- Outputs drive directly from the pending register.
- Per-edge update rules, applied in priority order:
  1. flush_en: clear pending if pending.robidx is not older than flush_robidx; discard new candidates that are not older than flush_robidx. A surviving older candidate may still load.
  2. Fire (redirect_valid & redirect_ready): pending clears. If a new candidate exists the same cycle, it loads instead.
  3. No fire, pending valid: replace pending only if the new candidate is older. Replacement while valid&~ready is legal; the consumer samples only on fire.
  4. Pending empty: load the new candidate if any.
- After firing robidx R, candidates not older than R are ignored until a flush_en arrives or 64 cycles pass. Mechanism: a "last-fired" register plus a blocking flag. The flag clears on flush_en with flush_robidx equal to or older than R, or on a reload from an older candidate.
- Non-error branches (br_error=0) never affect state.
- Reset (async, rst=0): pending valid=0, target=0, taken=0, robidx=0, fsqidx=0, block flag=0, counters=0. Reset mid-handshake drops the redirect with no fire.
- Target is passed through unmodified with no width arithmetic.

Optional Feature:
- Macro: BRU_PERF_COUNTER_EN.
- Defined: adds outputs perf_mispred (32 bit) and perf_replace (32 bit).
  - perf_mispred counts fires.
  - perf_replace counts pending replacements by an older candidate.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - RobIdx struct {dir, idx}
  - function rob_older(a,b)
  - BranchRedirect struct {target, taken, robidx, fsqidx}
  - ALU_NUM default constant
- Sub-module redirect_age_select: combinational log2(ALU_NUM) tree of rob_older compares. Returns {valid, winner index, payload}. Reusable by the exception/LSU violation paths.

Test Plan:
- Single mispredict: ALU2 error, robidx {0,5}, target 0x8000_0040, ready=1 → redirect_valid one cycle later with target 0x8000_0040, fsqidx passed through; deasserts next cycle.
- Simultaneous: ALU0 {0,9}, ALU3 {0,4}, ALU1 {1,2} all error → winner {0,4}. Then with {1,2} vs {0,60}, wrap case → {0,60} wins.
- Backpressure replace: ready=0, pending {0,10}; new error {0,7} → pending becomes {0,7}. A later {0,12} is ignored. Set ready=1 → one fire with {0,7}.
- Flush: pending {0,10}, flush_en with flush_robidx {0,8} → redirect_valid drops next cycle. The same-cycle candidate {0,3} loads and survives.
- Non-error branches: br_en=1, br_error=0 on all ALUs for 20 cycles → redirect_valid stays 0.
- Reset mid-operation: rst low while redirect_valid=1, ready=0 → all outputs 0 immediately (async). With BRU_PERF_COUNTER_EN, perf_mispred=0.
